// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch stage.
// The queue entry layout depends on instance parameters and is built in fetch_unit.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    HALT_WAIT = 2'd2
  } fetch_state_t;

  localparam logic [3:0] DEFAULT_HALT_OPCODE = 4'b1010;
  localparam int         DEFAULT_IMEM_DEPTH  = 2048;
  localparam int         DEFAULT_IMEM_WIDTH  = 16;
  localparam int         DEFAULT_ILEN        = 12;
  localparam int         DEFAULT_OPCODE_LEN  = 4;
  localparam int         DEFAULT_FQ_DEPTH    = 2;

  function automatic int fq_entry_w(input int ilen, input int pc_len);
    return ilen + pc_len;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO between instruction memory return and decode.
// Flush wins over push; DEPTH must be a power of two so the pointers wrap on their own.
module fetch_queue #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 23,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  input  logic              flush_i,
  output logic [DATA_W-1:0] data_o,
  output logic [CW-1:0]     count_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int PW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q;
  logic [PW-1:0]     rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic              do_push;
  logic              do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk) begin
    if (!rstn || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues reads to a 1-cycle synchronous memory and feeds decode
// through a valid/ready queue, with start PC, redirect/flush and clean stop on HALT.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   IDLE      | waiting for start; redirect ignored
//   RUN       | issuing fetches while queue + in-flight has room
//   HALT_WAIT | HALT queued, no issue; leaves with done once HALT is consumed
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                    IMEM_DEPTH  = DEFAULT_IMEM_DEPTH,
  parameter int                    IMEM_WIDTH  = DEFAULT_IMEM_WIDTH,
  parameter int                    ILEN        = DEFAULT_ILEN,
  parameter int                    OPCODE_LEN  = DEFAULT_OPCODE_LEN,
  parameter logic [OPCODE_LEN-1:0] HALT_OPCODE = OPCODE_LEN'(DEFAULT_HALT_OPCODE),
  parameter int                    FQ_DEPTH    = DEFAULT_FQ_DEPTH,
  localparam int                   PC_LEN      = $clog2(IMEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [PC_LEN-1:0]     start_pc,
  input  logic                  redirect_valid,
  input  logic [PC_LEN-1:0]     redirect_pc,
  output logic [PC_LEN-1:0]     instr_addr,
  output logic                  instr_en,
  input  logic [IMEM_WIDTH-1:0] instr_dout,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ILEN-1:0]       out_instr,
  output logic [PC_LEN-1:0]     out_pc,
  output logic                  busy,
  output logic                  done
);

  typedef struct packed {
    logic [ILEN-1:0]   instr;
    logic [PC_LEN-1:0] pc;
  } fq_entry_t;

  localparam int FQ_W = fq_entry_w(ILEN, PC_LEN);
  localparam int CW   = $clog2(FQ_DEPTH) + 1;
  localparam int OW   = CW + 1;

  fetch_state_t      state_q;
  logic [PC_LEN-1:0] pc_q;
  logic [PC_LEN-1:0] inflight_pc_q;
  logic              inflight_q;
  logic              done_q;

  logic [CW-1:0]     fq_count;
  logic              fq_empty;
  logic              unused_fq_full;
  logic [FQ_W-1:0]   fq_head_bits;
  fq_entry_t         fq_head;
  fq_entry_t         ret_entry;

  logic [ILEN-1:0]   ret_instr;
  logic [PC_LEN-1:0] next_pc;
  logic [OW-1:0]     occupancy;
  logic              deq;
  logic              redirect;
  logic              issue;
  logic              ret_push;
  logic              halt_push;

  assign ret_instr = instr_dout[ILEN-1:0];
  assign deq       = out_valid && out_ready;
  assign redirect  = redirect_valid && (state_q != IDLE);
  // Redirect drops whatever is returning this cycle as well as the queue contents.
  assign ret_push  = inflight_q && !redirect;
  assign halt_push = ret_push && (state_q == RUN) &&
                     (ret_instr[OPCODE_LEN-1:0] == HALT_OPCODE);

  assign occupancy = OW'(fq_count) + OW'(inflight_q) - OW'(deq);
  assign issue     = (state_q == RUN) && !redirect && (occupancy < OW'(FQ_DEPTH));
  assign next_pc   = (pc_q == PC_LEN'(IMEM_DEPTH - 1)) ? '0 : pc_q + 1'b1;

  assign instr_en   = issue;
  assign instr_addr = issue ? pc_q : '0;

  assign ret_entry = '{instr: ret_instr, pc: inflight_pc_q};
  assign fq_head   = fq_entry_t'(fq_head_bits);

  assign out_valid = !fq_empty;
  assign out_instr = out_valid ? fq_head.instr : '0;
  assign out_pc    = out_valid ? fq_head.pc : '0;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

  fetch_queue #(
    .DEPTH  (FQ_DEPTH),
    .DATA_W (FQ_W)
  ) u_fetch_queue (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (ret_push),
    .data_i  (ret_entry),
    .pop_i   (deq),
    .flush_i (redirect),
    .data_o  (fq_head_bits),
    .count_o (fq_count),
    .full_o  (unused_fq_full),
    .empty_o (fq_empty)
  );

  if (IMEM_WIDTH > ILEN) begin : g_unused_hi
    logic unused_dout_hi;
    assign unused_dout_hi = ^instr_dout[IMEM_WIDTH-1:ILEN];
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q       <= IDLE;
      pc_q          <= '0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      done_q        <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // A fetch issued alongside the HALT return is killed so nothing past HALT lands.
      inflight_q <= issue && !halt_push;
      if (issue) begin
        inflight_pc_q <= pc_q;
        pc_q          <= next_pc;
      end
      if (redirect) begin
        state_q <= RUN;
        pc_q    <= redirect_pc;
      end else begin
        case (state_q)
          IDLE: begin
            if (start) begin
              state_q <= RUN;
              pc_q    <= start_pc;
            end
          end
          RUN: begin
            if (halt_push) state_q <= HALT_WAIT;
          end
          HALT_WAIT: begin
            if (deq && (fq_count == CW'(1))) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule
